fwd_src_pipe: RTL and testbench
===============================

// Module: fwd_src_pipe
// PURPOSE
//  Producer side of operand forwarding: carries each instruction's destination register, result kind and
//  result data through the EX, MEM and WB stages, and publishes per-stage rd/kind/data to the forwarding
//  unit and the register-file write port. Holds the pipe while a load waits for mem_ack_i, on external
//  stall, and clears the EX slot on flush. Sits between decode and the register file.
// PARAMETERS
//  XLEN      32  data width of results and load data
//  REG_AW    5   register-index width
// PORTS
//  clk_i         in   1       clock; all state changes on rising edge
//  rst_i         in   1       synchronous, active-high reset
//  id_rd_i       in   REG_AW  destination register of instruction entering EX
//  id_kind_i     in   2       00 no write, 01 ALU (result ready at end of EX), 10 load (ready on mem_ack_i)
//  stall_i       in   1       external hold request (e.g. hazard stall)
//  flush_i       in   1       kill instruction entering/sitting in EX
//  ex_result_i   in   XLEN    EX-stage result of the instruction in the EX slot
//  mem_rdata_i   in   XLEN    load data, valid when mem_ack_i=1
//  mem_ack_i     in   1       load completion strobe for the load in MEM
//  ex_rd_o       out  REG_AW  EX slot rd; 0 if kind 00 or bubble
//  ex_inst_o     out  2       EX slot kind
//  mem_rd_o      out  REG_AW  MEM slot rd; 0 if kind 00 or bubble
//  mem_inst_o    out  2       MEM slot kind; load already captured reports 01
//  mem_dat_o     out  XLEN    MEM slot result (ALU result, or captured load data)
//  wb_rd_o       out  REG_AW  WB slot rd; 0 if kind 00 or bubble
//  wb_dat_o      out  XLEN    WB slot result
//  wb_we_o       out  1       register-file write enable, one cycle per retired writing instruction
//  mem_busy_o    out  1       pipe held waiting for load data (combinational)
// BEHAVIOUR
//  - Slots: EX{v,rd,kind}, MEM{v,rd,kind,dat,done}, WB{v,rd,dat,fresh}. Bubble = v=0, outputs rd 0, kind 00.
//  - mem_wait = MEM.v & MEM.kind==10 & !MEM.done & !mem_ack_i; mem_busy_o = mem_wait.
//  - hold = stall_i | mem_wait. advance = !hold.
//  - On advance: WB <= MEM (dat = mem_rdata_i if load acked this cycle, else MEM.dat), WB.fresh<=1;
//    MEM <= EX with dat=ex_result_i, done=0; EX <= flush_i ? bubble : {1,id_rd_i,id_kind_i}.
//  - On hold: WB/MEM/EX retain; WB.fresh<=0; if flush_i, EX <= bubble (flush beats hold for EX only).
//  - Load ack while held (stall_i=1): MEM.dat<=mem_rdata_i, MEM.done<=1; later ack ignored for this entry.
//  - mem_ack_i with no un-acked load in MEM: ignored.
//  - wb_we_o = WB.v & WB.fresh & WB.kind!=00 & WB.rd!=0. Register x0 never written nor forwarded (rd_o=0).
//  - Latency: ALU result published on mem_dat_o 1 cycle after leaving EX, on wb_dat_o 2 cycles after.
//  - Reset (rst_i=1 on edge): all slots bubble, data 0, fresh 0; all outputs 0. Reset mid-load drops the load.
//  - Kind 11 reserved: treated as 00.
// TESTING
//  1 ALU stream: rd=5,kind 01,ex_result 0x11 -> next cycle mem_rd_o=5,mem_dat_o=0x11; next wb_we_o=1,wb_dat_o=0x11.
//  2 Load rd=7 in MEM, ack after 3 cycles with 0xDEADBEEF -> mem_busy_o=1 for 3 cycles, EX/MEM frozen, then
//    wb_rd_o=7, wb_dat_o=0xDEADBEEF, wb_we_o=1 exactly one cycle.
//  3 stall_i=1 for 2 cycles, load acked during stall -> mem_inst_o switches 10->01, mem_dat_o=ack data, no double write.
//  4 flush_i with id_rd_i=9 -> ex_rd_o=0, ex_inst_o=00 next cycle; 3 cycles later wb_we_o stays 0.
//  5 rd=0 kind 01 -> all rd_o=0 as it travels, wb_we_o=0.
//  6 rst_i asserted while load waits -> next cycle all outputs 0, mem_busy_o=0; later stray mem_ack_i ignored.

Source files
------------

// File: rtl/fwd_src_pipe.sv
// Producer side of operand forwarding: carries rd/kind/result through EX, MEM and WB,
// and publishes per-stage forwarding info plus the register-file write port.
module fwd_src_pipe #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic [1:0]        id_kind_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [XLEN-1:0]   ex_result_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [1:0]        ex_inst_o,
   output logic [REG_AW-1:0] mem_rd_o,
   output logic [1:0]        mem_inst_o,
   output logic [XLEN-1:0]   mem_dat_o,
   output logic [REG_AW-1:0] wb_rd_o,
   output logic [XLEN-1:0]   wb_dat_o,
   output logic              wb_we_o,
   output logic              mem_busy_o
);

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_ALU  = 2'b01;
   localparam logic [1:0] KIND_LOAD = 2'b10;

   logic              ex_v_q, ex_v_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic [1:0]        ex_kind_q, ex_kind_d;

   logic              mem_v_q, mem_v_d;
   logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
   logic [1:0]        mem_kind_q, mem_kind_d;
   logic [XLEN-1:0]   mem_dat_q, mem_dat_d;
   logic              mem_done_q, mem_done_d;

   logic              wb_v_q, wb_v_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic [1:0]        wb_kind_q, wb_kind_d;
   logic [XLEN-1:0]   wb_dat_q, wb_dat_d;
   logic              wb_fresh_q, wb_fresh_d;

   logic [1:0] id_kind;
   logic       mem_load_pend;
   logic       load_data_now;
   logic       mem_wait;
   logic       hold;

   always_comb begin
      // Reserved kind 11 enters the pipe as a non-writing instruction.
      id_kind       = (id_kind_i == 2'b11) ? KIND_NONE : id_kind_i;
      mem_load_pend = mem_v_q && (mem_kind_q == KIND_LOAD) && !mem_done_q;
      load_data_now = mem_load_pend && mem_ack_i;
      mem_wait      = mem_load_pend && !mem_ack_i;
      hold          = stall_i || mem_wait;

      ex_v_d     = ex_v_q;
      ex_rd_d    = ex_rd_q;
      ex_kind_d  = ex_kind_q;
      mem_v_d    = mem_v_q;
      mem_rd_d   = mem_rd_q;
      mem_kind_d = mem_kind_q;
      mem_dat_d  = mem_dat_q;
      mem_done_d = mem_done_q;
      wb_v_d     = wb_v_q;
      wb_rd_d    = wb_rd_q;
      wb_kind_d  = wb_kind_q;
      wb_dat_d   = wb_dat_q;
      wb_fresh_d = 1'b0;

      if (!hold) begin
         wb_v_d     = mem_v_q;
         wb_rd_d    = mem_rd_q;
         wb_kind_d  = mem_kind_q;
         wb_dat_d   = load_data_now ? mem_rdata_i : mem_dat_q;
         wb_fresh_d = 1'b1;
         mem_v_d    = ex_v_q;
         mem_rd_d   = ex_rd_q;
         mem_kind_d = ex_kind_q;
         mem_dat_d  = ex_result_i;
         mem_done_d = 1'b0;
         ex_v_d     = !flush_i;
         ex_rd_d    = flush_i ? '0 : id_rd_i;
         ex_kind_d  = flush_i ? KIND_NONE : id_kind;
      end else begin
         // An ack during an external stall is captured so the load never re-waits.
         if (load_data_now) begin
            mem_dat_d  = mem_rdata_i;
            mem_done_d = 1'b1;
         end
         if (flush_i) begin
            ex_v_d    = 1'b0;
            ex_rd_d   = '0;
            ex_kind_d = KIND_NONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_v_q     <= 1'b0;
         ex_rd_q    <= '0;
         ex_kind_q  <= KIND_NONE;
         mem_v_q    <= 1'b0;
         mem_rd_q   <= '0;
         mem_kind_q <= KIND_NONE;
         mem_dat_q  <= '0;
         mem_done_q <= 1'b0;
         wb_v_q     <= 1'b0;
         wb_rd_q    <= '0;
         wb_kind_q  <= KIND_NONE;
         wb_dat_q   <= '0;
         wb_fresh_q <= 1'b0;
      end else begin
         ex_v_q     <= ex_v_d;
         ex_rd_q    <= ex_rd_d;
         ex_kind_q  <= ex_kind_d;
         mem_v_q    <= mem_v_d;
         mem_rd_q   <= mem_rd_d;
         mem_kind_q <= mem_kind_d;
         mem_dat_q  <= mem_dat_d;
         mem_done_q <= mem_done_d;
         wb_v_q     <= wb_v_d;
         wb_rd_q    <= wb_rd_d;
         wb_kind_q  <= wb_kind_d;
         wb_dat_q   <= wb_dat_d;
         wb_fresh_q <= wb_fresh_d;
      end
   end

   assign ex_inst_o  = ex_v_q ? ex_kind_q : KIND_NONE;
   assign ex_rd_o    = (ex_v_q && ex_kind_q != KIND_NONE) ? ex_rd_q : '0;
   assign mem_inst_o = !mem_v_q ? KIND_NONE :
                       (mem_kind_q == KIND_LOAD && mem_done_q) ? KIND_ALU : mem_kind_q;
   assign mem_rd_o   = (mem_v_q && mem_kind_q != KIND_NONE) ? mem_rd_q : '0;
   assign mem_dat_o  = mem_dat_q;
   assign wb_rd_o    = (wb_v_q && wb_kind_q != KIND_NONE) ? wb_rd_q : '0;
   assign wb_dat_o   = wb_dat_q;
   assign wb_we_o    = wb_v_q && wb_fresh_q && (wb_kind_q != KIND_NONE) && (wb_rd_q != '0);
   assign mem_busy_o = mem_wait;

endmodule

// File: tb/tb_fwd_src_pipe.sv
// Directed bench for fwd_src_pipe: a vector table for the streaming cases plus
// hand-written sequences for load waits, stalls with early ack, and reset mid-load.
module tb_fwd_src_pipe;

   typedef struct {
      logic        rst;
      logic [4:0]  rd;
      logic [1:0]  kind;
      logic        stall;
      logic        flush;
      logic [31:0] exres;
      logic [31:0] rdata;
      logic        ack;
      logic [4:0]  e_ex_rd;
      logic [1:0]  e_ex_inst;
      logic [4:0]  e_mem_rd;
      logic [1:0]  e_mem_inst;
      logic [31:0] e_mem_dat;
      logic [4:0]  e_wb_rd;
      logic [31:0] e_wb_dat;
      logic        e_wb_we;
      logic        e_busy;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  id_rd_i;
   logic [1:0]  id_kind_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] ex_result_i;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic [4:0]  ex_rd_o;
   logic [1:0]  ex_inst_o;
   logic [4:0]  mem_rd_o;
   logic [1:0]  mem_inst_o;
   logic [31:0] mem_dat_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_dat_o;
   logic        wb_we_o;
   logic        mem_busy_o;

   int    checks = 0;
   int    errors = 0;
   string tag;
   vec_t  table_v[9];

   fwd_src_pipe #(.XLEN(32), .REG_AW(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_rd_i(id_rd_i), .id_kind_i(id_kind_i),
      .stall_i(stall_i), .flush_i(flush_i), .ex_result_i(ex_result_i),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .ex_rd_o(ex_rd_o),
      .ex_inst_o(ex_inst_o), .mem_rd_o(mem_rd_o), .mem_inst_o(mem_inst_o),
      .mem_dat_o(mem_dat_o), .wb_rd_o(wb_rd_o), .wb_dat_o(wb_dat_o),
      .wb_we_o(wb_we_o), .mem_busy_o(mem_busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic vec_t mk(
      input logic rst, input logic [4:0] rd, input logic [1:0] kind,
      input logic stall, input logic flush, input logic [31:0] exres,
      input logic [31:0] rdata, input logic ack,
      input logic [4:0] e_ex_rd, input logic [1:0] e_ex_inst,
      input logic [4:0] e_mem_rd, input logic [1:0] e_mem_inst, input logic [31:0] e_mem_dat,
      input logic [4:0] e_wb_rd, input logic [31:0] e_wb_dat, input logic e_wb_we,
      input logic e_busy);
      vec_t v;
      v.rst = rst; v.rd = rd; v.kind = kind; v.stall = stall; v.flush = flush;
      v.exres = exres; v.rdata = rdata; v.ack = ack;
      v.e_ex_rd = e_ex_rd; v.e_ex_inst = e_ex_inst; v.e_mem_rd = e_mem_rd;
      v.e_mem_inst = e_mem_inst; v.e_mem_dat = e_mem_dat; v.e_wb_rd = e_wb_rd;
      v.e_wb_dat = e_wb_dat; v.e_wb_we = e_wb_we; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst_i       = v.rst;
      id_rd_i     = v.rd;
      id_kind_i   = v.kind;
      stall_i     = v.stall;
      flush_i     = v.flush;
      ex_result_i = v.exres;
      mem_rdata_i = v.rdata;
      mem_ack_i   = v.ack;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s %s: got %h expected %h", tag, name, act, exp);
      end
   endtask

   task automatic checkOutput(input vec_t v);
      chk("ex_rd_o",    32'(ex_rd_o),    32'(v.e_ex_rd));
      chk("ex_inst_o",  32'(ex_inst_o),  32'(v.e_ex_inst));
      chk("mem_rd_o",   32'(mem_rd_o),   32'(v.e_mem_rd));
      chk("mem_inst_o", 32'(mem_inst_o), 32'(v.e_mem_inst));
      chk("mem_dat_o",  mem_dat_o,       v.e_mem_dat);
      chk("wb_rd_o",    32'(wb_rd_o),    32'(v.e_wb_rd));
      chk("wb_dat_o",   wb_dat_o,        v.e_wb_dat);
      chk("wb_we_o",    32'(wb_we_o),    32'(v.e_wb_we));
      chk("mem_busy_o", 32'(mem_busy_o), 32'(v.e_busy));
   endtask

   // Inputs change on the falling edge; outputs are checked 1 time unit later.
   task automatic runVec(input string name, input vec_t v);
      @(negedge clk_i);
      tag = name;
      applyStimulus(v);
      #1;
      checkOutput(v);
   endtask

   task automatic doReset();
      @(negedge clk_i);
      applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      doReset();

      // ALU stream, x0 destination, flush of rd 9, kind 00/11 and a stray ack.
      table_v[0] = mk(0, 5, 1, 0, 0, 'h00,  0,    0, 0, 0, 0, 0, 'h00, 0, 'h00, 0, 0);
      table_v[1] = mk(0, 6, 1, 0, 0, 'h11,  0,    0, 5, 1, 0, 0, 'h00, 0, 'h00, 0, 0);
      table_v[2] = mk(0, 0, 1, 0, 0, 'h22,  0,    0, 6, 1, 5, 1, 'h11, 0, 'h00, 0, 0);
      table_v[3] = mk(0, 9, 1, 0, 1, 'h33,  0,    0, 0, 1, 6, 1, 'h22, 5, 'h11, 1, 0);
      table_v[4] = mk(0, 3, 0, 0, 0, 'h44,  0,    0, 0, 0, 0, 1, 'h33, 6, 'h22, 1, 0);
      table_v[5] = mk(0, 4, 3, 0, 0, 'h55,  0,    0, 0, 0, 0, 0, 'h44, 0, 'h33, 0, 0);
      table_v[6] = mk(0, 0, 0, 0, 0, 'h66,  0,    0, 0, 0, 0, 0, 'h55, 0, 'h44, 0, 0);
      table_v[7] = mk(0, 0, 0, 0, 0, 'h00, 'hBAD, 1, 0, 0, 0, 0, 'h66, 0, 'h55, 0, 0);
      table_v[8] = mk(0, 0, 0, 0, 0, 'h00,  0,    0, 0, 0, 0, 0, 'h00, 0, 'h66, 0, 0);
      for (int i = 0; i < 9; i++) runVec($sformatf("tbl%0d", i), table_v[i]);

      // Load rd 7 waits three cycles for its ack, then retires once.
      doReset();
      runVec("ld_a", mk(0, 7, 2, 0, 0, 'h0,    0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0));
      runVec("ld_b", mk(0, 8, 1, 0, 0, 'h1000, 0, 0, 7, 2, 0, 0, 'h0,    0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         runVec($sformatf("ld_wait%0d", i),
                mk(0, 9, 1, 0, 0, 'h2222, 0, 0, 8, 1, 7, 2, 'h1000, 0, 0, 0, 1));
      runVec("ld_ack", mk(0, 9, 1, 0, 0, 'h8888, 'hDEADBEEF, 1, 8, 1, 7, 2, 'h1000, 0, 0, 0, 0));
      runVec("ld_wb",  mk(0, 0, 0, 0, 0, 'h9999, 0, 0, 9, 1, 8, 1, 'h8888, 7, 'hDEADBEEF, 1, 0));
      runVec("ld_nxt", mk(0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0, 9, 1, 'h9999, 8, 'h8888, 1, 0));

      // Load acked during an external stall; a later ack is ignored and no double write occurs.
      doReset();
      runVec("st_a", mk(0, 10, 1'b0 ? 0 : 2, 0, 0, 'h0,  0, 0, 0, 0, 0, 0, 'h0, 0, 0, 0, 0));
      runVec("st_b", mk(0, 11, 1, 0, 0, 'h40, 0, 0, 10, 2, 0, 0, 'h0, 0, 0, 0, 0));
      runVec("st_c", mk(0, 12, 1, 1, 0, 'h0, 'hCAFEF00D, 1, 11, 1, 10, 2, 'h40, 0, 0, 0, 0));
      runVec("st_d", mk(0, 12, 1, 1, 0, 'h0, 0, 0, 11, 1, 10, 1, 'hCAFEF00D, 0, 0, 0, 0));
      runVec("st_e", mk(0, 12, 1, 0, 0, 'h1111, 'h12345678, 1, 11, 1, 10, 1, 'hCAFEF00D, 0, 0, 0, 0));
      runVec("st_f", mk(0, 0, 0, 1, 0, 'h0, 0, 0, 12, 1, 11, 1, 'h1111, 10, 'hCAFEF00D, 1, 0));
      runVec("st_g", mk(0, 0, 0, 0, 0, 'h2222, 0, 0, 12, 1, 11, 1, 'h1111, 10, 'hCAFEF00D, 0, 0));
      runVec("st_h", mk(0, 0, 0, 0, 0, 'h0, 0, 0, 0, 0, 12, 1, 'h2222, 11, 'h1111, 1, 0));

      // Reset while a load waits drops it; a later stray ack has no effect.
      doReset();
      runVec("rs_a", mk(0, 13, 2, 0, 0, 'h0,  0, 0, 0, 0, 0, 0, 'h0, 0, 0, 0, 0));
      runVec("rs_b", mk(0, 0, 0, 0, 0, 'h50, 0, 0, 13, 2, 0, 0, 'h0, 0, 0, 0, 0));
      runVec("rs_c", mk(1, 0, 0, 0, 0, 'h0,  0, 0, 0, 0, 13, 2, 'h50, 0, 0, 0, 1));
      runVec("rs_d", mk(0, 0, 0, 0, 0, 'h0,  0, 0, 0, 0, 0, 0, 'h0, 0, 0, 0, 0));
      runVec("rs_e", mk(0, 0, 0, 0, 0, 'h0, 'hFFFFFFFF, 1, 0, 0, 0, 0, 'h0, 0, 0, 0, 0));
      runVec("rs_f", mk(0, 0, 0, 0, 0, 'h0,  0, 0, 0, 0, 0, 0, 'h0, 0, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
